// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit and its datapath muxes.
// The optional M-extension sequencing is enabled with the M_EXT_EN macro.
package cu_pkg;

    localparam logic [3:0] StReset    = 4'd0;
    localparam logic [3:0] StFetch    = 4'd1;
    localparam logic [3:0] StDecode   = 4'd2;
    localparam logic [3:0] StMemAddr  = 4'd3;
    localparam logic [3:0] StMemRead  = 4'd4;
    localparam logic [3:0] StMemWrite = 4'd5;
    localparam logic [3:0] StWbMem    = 4'd6;
    localparam logic [3:0] StExecR    = 4'd7;
    localparam logic [3:0] StExecI    = 4'd8;
    localparam logic [3:0] StExecU    = 4'd9;
    localparam logic [3:0] StWbAlu    = 4'd10;
    localparam logic [3:0] StBranch   = 4'd11;
    localparam logic [3:0] StJal      = 4'd12;
    localparam logic [3:0] StJalr     = 4'd13;
    localparam logic [3:0] StMuldiv   = 4'd14;
    localparam logic [3:0] StTrap     = 4'd15;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpOpImm  = 7'b0010011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    localparam logic [1:0] AluSrcAPc    = 2'b00;
    localparam logic [1:0] AluSrcARs1   = 2'b01;
    localparam logic [1:0] AluSrcAOldPc = 2'b10;
    localparam logic [1:0] AluSrcAZero  = 2'b11;

    localparam logic [1:0] AluSrcBRs2  = 2'b00;
    localparam logic [1:0] AluSrcBFour = 2'b01;
    localparam logic [1:0] AluSrcBImm  = 2'b10;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpCmp   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJalr   = 2'b10;

    localparam logic [1:0] MemToRegAluOut = 2'b00;
    localparam logic [1:0] MemToRegMem    = 2'b01;
    localparam logic [1:0] MemToRegPc     = 2'b10;
    localparam logic [1:0] MemToRegMuldiv = 2'b11;

    // States that stall on the shared memory port's ready handshake.
    function automatic logic is_mem_wait_state(input logic [3:0] st);
        return (st == StFetch) || (st == StMemRead) || (st == StMemWrite);
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control unit <-> instruction register / datapath bundle.
// muldiv_done exists only when M_EXT_EN is defined.
interface multicycle_control_unit_if;

    logic [6:0] opcode;
    logic       funct7_0;
    logic       mem_ready;
`ifdef M_EXT_EN
    logic       muldiv_done;
`endif
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       iord;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic [1:0] pc_src;
    logic [1:0] mem_to_reg;
    logic       muldiv_start;
    logic       illegal;
    logic       fault;
    logic [3:0] state_o;

    modport master (
        input  opcode, funct7_0, mem_ready,
`ifdef M_EXT_EN
        input  muldiv_done,
`endif
        output pc_write, ir_write, reg_write, mem_read, mem_write, branch, iord,
        output alu_src_a, alu_src_b, aluop, pc_src, mem_to_reg, muldiv_start,
        output illegal, fault, state_o
    );

    modport slave (
        output opcode, funct7_0, mem_ready,
`ifdef M_EXT_EN
        output muldiv_done,
`endif
        input  pc_write, ir_write, reg_write, mem_read, mem_write, branch, iord,
        input  alu_src_a, alu_src_b, aluop, pc_src, mem_to_reg, muldiv_start,
        input  illegal, fault, state_o
    );

endinterface

// File: rtl/cu_timeout_counter.sv
// Consecutive wait-cycle counter; expired flags the TIMEOUT_CYCLES-th wait cycle.
// TIMEOUT_CYCLES of 0 disables expiry entirely.
module cu_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int unsigned W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [W-1:0] Last = (TIMEOUT_CYCLES > 0) ? W'(TIMEOUT_CYCLES - 1) : '0;

    logic [W-1:0] cnt_q;

    // Expiry is combinational so that the fault lands on the very next state.
    assign expired = (TIMEOUT_CYCLES != 0) && count && (cnt_q == Last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (count && !expired && (TIMEOUT_CYCLES != 0)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore-style multi-cycle RV32I control FSM sharing one memory port and one ALU.
// Define M_EXT_EN to add the MULDIV state that sequences an external M unit.
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                       clk,
    input logic                       rst_n,
    multicycle_control_unit_if.master bus
);

    logic [3:0] state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       fault_q, fault_d;
    logic       waiting, expired, tmo_clear;
`ifdef M_EXT_EN
    logic       in_muldiv_q;
`else
    logic       unused_funct7;
    assign unused_funct7 = bus.funct7_0;
`endif

    always_comb begin
        waiting = is_mem_wait_state(state_q) && !bus.mem_ready;
`ifdef M_EXT_EN
        if (state_q == StMuldiv) begin
            waiting = !bus.muldiv_done;
        end
`endif
    end

    assign tmo_clear = (state_d != state_q);

    cu_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmo_clear),
        .count   (waiting),
        .expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        fault_d   = fault_q;
        case (state_q)
            StReset:    state_d = StFetch;
            StFetch:    if (bus.mem_ready) state_d = StDecode;
            StDecode: begin
                case (bus.opcode)
                    OpLoad, OpStore: state_d = StMemAddr;
                    OpOp:            state_d = StExecR;
                    OpOpImm:         state_d = StExecI;
                    OpLui, OpAuipc:  state_d = StExecU;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalr;
                    default: begin
                        state_d   = StTrap;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StMemAddr:  state_d = (bus.opcode == OpStore) ? StMemWrite : StMemRead;
            StMemRead:  if (bus.mem_ready) state_d = StWbMem;
            StMemWrite: if (bus.mem_ready) state_d = StFetch;
`ifdef M_EXT_EN
            StExecR:    state_d = bus.funct7_0 ? StMuldiv : StWbAlu;
            StMuldiv:   if (bus.muldiv_done) state_d = StFetch;
`else
            StExecR:    state_d = StWbAlu;
`endif
            StExecI, StExecU: state_d = StWbAlu;
            StWbMem, StWbAlu, StBranch, StJal, StJalr: state_d = StFetch;
            StTrap:     state_d = StTrap;
            default:    state_d = StTrap;
        endcase
        // Only reachable while still waiting, so a same-cycle ready always wins.
        if (expired) begin
            state_d = StTrap;
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StReset;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            fault_q   <= fault_d;
        end
    end

`ifdef M_EXT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_muldiv_q <= 1'b0;
        end else begin
            in_muldiv_q <= (state_q == StMuldiv);
        end
    end
`endif

    always_comb begin
        bus.pc_write     = 1'b0;
        bus.ir_write     = 1'b0;
        bus.reg_write    = 1'b0;
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.branch       = 1'b0;
        bus.iord         = 1'b0;
        bus.alu_src_a    = AluSrcAPc;
        bus.alu_src_b    = AluSrcBRs2;
        bus.aluop        = AluOpAdd;
        bus.pc_src       = PcSrcAlu;
        bus.mem_to_reg   = MemToRegAluOut;
        bus.muldiv_start = 1'b0;
        case (state_q)
            StFetch: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = AluSrcBFour;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            StDecode: begin
                // Precompute branch/JAL target into ALUOut.
                bus.alu_src_a = AluSrcAOldPc;
                bus.alu_src_b = AluSrcBImm;
            end
            StMemAddr: begin
                bus.alu_src_a = AluSrcARs1;
                bus.alu_src_b = AluSrcBImm;
            end
            StMemRead: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
            end
            StMemWrite: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
            end
            StWbMem: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = MemToRegMem;
            end
            StExecR: begin
                bus.alu_src_a = AluSrcARs1;
                bus.aluop     = AluOpFunct;
            end
            StExecI: begin
                bus.alu_src_a = AluSrcARs1;
                bus.alu_src_b = AluSrcBImm;
                bus.aluop     = AluOpFunct;
            end
            StExecU: begin
                bus.alu_src_a = (bus.opcode == OpLui) ? AluSrcAZero : AluSrcAOldPc;
                bus.alu_src_b = AluSrcBImm;
            end
            StWbAlu:  bus.reg_write = 1'b1;
            StBranch: begin
                bus.alu_src_a = AluSrcARs1;
                bus.aluop     = AluOpCmp;
                bus.branch    = 1'b1;
                bus.pc_src    = PcSrcAluOut;
            end
            StJal: begin
                bus.pc_write   = 1'b1;
                bus.pc_src     = PcSrcAluOut;
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = MemToRegPc;
            end
            StJalr: begin
                bus.alu_src_a  = AluSrcARs1;
                bus.alu_src_b  = AluSrcBImm;
                bus.pc_write   = 1'b1;
                bus.pc_src     = PcSrcJalr;
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = MemToRegPc;
            end
`ifdef M_EXT_EN
            StMuldiv: begin
                bus.muldiv_start = !in_muldiv_q;
                bus.reg_write    = bus.muldiv_done;
                bus.mem_to_reg   = MemToRegMuldiv;
            end
`endif
            default: ;
        endcase
    end

    assign bus.illegal = illegal_q;
    assign bus.fault   = fault_q;
    assign bus.state_o = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: phase-list reference model, vector table,
// and hand sequences for reset, trap and timeout; MULDIV sequence only under M_EXT_EN.
module tb_multicycle_control_unit;
    import cu_pkg::*;

    localparam int PhFetch = 0, PhDecode = 1, PhMemAddr = 2, PhMemRead = 3, PhMemWrite = 4;
    localparam int PhWbMem = 5, PhExecR = 6, PhExecI = 7, PhExecU = 8, PhWbAlu = 9;
    localparam int PhBranch = 10, PhJal = 11, PhJalr = 12;

    typedef struct {
        int   ph;
        logic mem;
        logic rdy;
    } step_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        int         fw;
        int         mw;
        int         cycles;
        int         rw;
        int         acc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_to_n;
    int   n_cmp = 0;
    int   n_err = 0;
    step_t      plan[$];
    vec_t       vecs[12];
    logic [6:0] legal[9];

    always #5 clk = ~clk;

    multicycle_control_unit_if bus0 ();
    multicycle_control_unit_if bus1 ();

    multicycle_control_unit #(.TIMEOUT_CYCLES(255)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    multicycle_control_unit #(.TIMEOUT_CYCLES(4)) u_to (
        .clk   (clk),
        .rst_n (rst_to_n),
        .bus   (bus1)
    );

    logic [17:0] got0, got1;
    assign got0 = {bus0.pc_write, bus0.ir_write, bus0.reg_write, bus0.mem_read, bus0.mem_write,
                   bus0.branch, bus0.iord, bus0.alu_src_a, bus0.alu_src_b, bus0.aluop,
                   bus0.pc_src, bus0.mem_to_reg, bus0.muldiv_start};
    assign got1 = {bus1.pc_write, bus1.ir_write, bus1.reg_write, bus1.mem_read, bus1.mem_write,
                   bus1.branch, bus1.iord, bus1.alu_src_a, bus1.alu_src_b, bus1.aluop,
                   bus1.pc_src, bus1.mem_to_reg, bus1.muldiv_start};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [17:0] cw(input logic pcw, input logic irw, input logic rw,
                                       input logic mr, input logic mw, input logic br,
                                       input logic io, input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] op, input logic [1:0] ps,
                                       input logic [1:0] m2r);
        return {pcw, irw, rw, mr, mw, br, io, a, b, op, ps, m2r, 1'b0};
    endfunction

    // Expected control word for each phase, straight from the phase descriptions.
    function automatic logic [17:0] exp_ctrl(input int ph, input logic rdy, input logic [6:0] op);
        case (ph)
            PhFetch:    return cw(rdy, rdy, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                  2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
            PhDecode:   return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
            PhMemAddr:  return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  2'b01, 2'b10, 2'b00, 2'b00, 2'b00);
            PhMemRead:  return cw(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                                  2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
            PhMemWrite: return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                                  2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
            PhWbMem:    return cw(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                  2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
            PhExecR:    return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  2'b01, 2'b00, 2'b10, 2'b00, 2'b00);
            PhExecI:    return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  2'b01, 2'b10, 2'b10, 2'b00, 2'b00);
            PhExecU:    return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  (op == 7'b0110111) ? 2'b11 : 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
            PhWbAlu:    return cw(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                  2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
            PhBranch:   return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                  2'b01, 2'b00, 2'b01, 2'b01, 2'b00);
            PhJal:      return cw(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                  2'b00, 2'b00, 2'b00, 2'b01, 2'b10);
            PhJalr:     return cw(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                  2'b01, 2'b10, 2'b00, 2'b10, 2'b10);
            default:    return '0;
        endcase
    endfunction

    function automatic void add_mem(input int ph, input int waits);
        step_t s;
        for (int i = 0; i <= waits; i++) begin
            s.ph  = ph;
            s.mem = 1'b1;
            s.rdy = (i == waits);
            plan.push_back(s);
        end
    endfunction

    function automatic void add_step(input int ph);
        step_t s;
        s.ph  = ph;
        s.mem = 1'b0;
        s.rdy = 1'b0;
        plan.push_back(s);
    endfunction

    function automatic void build(input logic [6:0] op, input int fw, input int mw);
        plan.delete();
        add_mem(PhFetch, fw);
        add_step(PhDecode);
        case (op)
            7'b0000011: begin add_step(PhMemAddr); add_mem(PhMemRead, mw); add_step(PhWbMem); end
            7'b0100011: begin add_step(PhMemAddr); add_mem(PhMemWrite, mw); end
            7'b0110011: begin add_step(PhExecR); add_step(PhWbAlu); end
            7'b0010011: begin add_step(PhExecI); add_step(PhWbAlu); end
            7'b0110111, 7'b0010111: begin add_step(PhExecU); add_step(PhWbAlu); end
            7'b1100011: add_step(PhBranch);
            7'b1101111: add_step(PhJal);
            7'b1100111: add_step(PhJalr);
            default: ;
        endcase
    endfunction

    // Runs up to max_steps of the plan; mem_ready is random wherever it must be ignored.
    task automatic run_plan(input logic [6:0] op, input string tag, input int max_steps);
        foreach (plan[i]) begin
            if (i < max_steps) begin
                @(posedge clk);
                #1;
                bus0.opcode    = op;
                bus0.mem_ready = plan[i].mem ? plan[i].rdy : 1'($urandom_range(1));
                @(negedge clk);
                check($sformatf("%s step %0d", tag, i), {12'd0, bus0.illegal, bus0.fault, got0},
                      {14'd0, exp_ctrl(plan[i].ph, plan[i].rdy, op)});
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        bus0.mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic timeout_seq(input int rdy_cycle, input string tag);
        rst_to_n       = 1'b0;
        bus1.mem_ready = 1'b0;
        bus1.opcode    = 7'b0110011;
        @(negedge clk);
        rst_to_n = 1'b1;
        @(posedge clk);  // RESET -> FETCH
        for (int c = 1; c <= 5; c++) begin
            #1;
            bus1.mem_ready = (c == rdy_cycle);
            @(negedge clk);
            if (c <= 4) begin
                check($sformatf("%s fetch c%0d", tag, c), {13'd0, bus1.fault, got1},
                      {14'd0, exp_ctrl(PhFetch, c == rdy_cycle, 7'b0110011)});
            end else if (rdy_cycle == 0) begin
                check($sformatf("%s trap", tag), {8'd0, bus1.fault, bus1.illegal, bus1.state_o, got1},
                      {8'd0, 1'b1, 1'b0, StTrap, 18'd0});
            end else begin
                check($sformatf("%s decode", tag), {8'd0, bus1.fault, bus1.illegal, bus1.state_o, got1},
                      {8'd0, 1'b0, 1'b0, StDecode, exp_ctrl(PhDecode, 1'b0, 7'b0110011)});
            end
            @(posedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{"R",        7'b0110011, 0, 0, 4, 1, 0};
        vecs[1]  = '{"I",        7'b0010011, 0, 0, 4, 1, 0};
        vecs[2]  = '{"LUI",      7'b0110111, 0, 0, 4, 1, 0};
        vecs[3]  = '{"AUIPC",    7'b0010111, 0, 0, 4, 1, 0};
        vecs[4]  = '{"store",    7'b0100011, 0, 0, 4, 0, 1};
        vecs[5]  = '{"load",     7'b0000011, 0, 0, 5, 1, 1};
        vecs[6]  = '{"load w3",  7'b0000011, 0, 3, 8, 1, 4};
        vecs[7]  = '{"store w2", 7'b0100011, 0, 2, 6, 0, 3};
        vecs[8]  = '{"branch",   7'b1100011, 0, 0, 3, 0, 0};
        vecs[9]  = '{"JAL",      7'b1101111, 0, 0, 3, 1, 0};
        vecs[10] = '{"JALR",     7'b1100111, 0, 0, 3, 1, 0};
        vecs[11] = '{"R fw2",    7'b0110011, 2, 0, 6, 1, 0};
        legal = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0110111,
                  7'b0010111, 7'b1100011, 7'b1101111, 7'b1100111};

        rst_n          = 1'b0;
        rst_to_n       = 1'b0;
        bus0.opcode    = 7'b0110011;
        bus0.funct7_0  = 1'b0;
        bus0.mem_ready = 1'b1;
        bus1.opcode    = 7'b0110011;
        bus1.funct7_0  = 1'b0;
        bus1.mem_ready = 1'b0;
`ifdef M_EXT_EN
        bus0.muldiv_done = 1'b0;
        bus1.muldiv_done = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset outputs", {12'd0, bus0.illegal, bus0.fault, got0}, 32'd0);
        check("reset state", {28'd0, bus0.state_o}, {28'd0, StReset});
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus0.mem_ready = 1'b0;
        @(negedge clk);
        check("first fetch", {14'd0, got0}, {14'd0, exp_ctrl(PhFetch, 1'b0, 7'b0110011)});

        // Vector table: latency, write-back count and data-access cycles per instruction.
        foreach (vecs[r]) begin
            int   cyc, rw, acc, fw_left, mw_left;
            logic fin, left_fetch;
            do_reset();
            bus0.opcode = vecs[r].op;
            cyc = 0; rw = 0; acc = 0; fin = 1'b0; left_fetch = 1'b0;
            fw_left = vecs[r].fw;
            mw_left = vecs[r].mw;
            for (int c = 0; c < 40 && !fin; c++) begin
                @(posedge clk);
                #1;
                if (left_fetch && bus0.mem_read && !bus0.iord) begin
                    fin = 1'b1;
                end else begin
                    cyc++;
                    if (bus0.mem_read && !bus0.iord) begin
                        bus0.mem_ready = (fw_left == 0);
                        if (fw_left > 0) fw_left--;
                    end else if (bus0.iord) begin
                        left_fetch = 1'b1;
                        acc++;
                        bus0.mem_ready = (mw_left == 0);
                        if (mw_left > 0) mw_left--;
                    end else begin
                        left_fetch = 1'b1;
                        bus0.mem_ready = 1'($urandom_range(1));
                    end
                    @(negedge clk);
                    if (bus0.reg_write) rw++;
                end
            end
            check({vecs[r].name, " cycles"}, cyc, vecs[r].cycles);
            check({vecs[r].name, " reg_write"}, rw, vecs[r].rw);
            check({vecs[r].name, " mem access"}, acc, vecs[r].acc);
        end

        // Randomized instruction stream, back to back.
        do_reset();
        for (int n = 0; n < 40; n++) begin
            logic [6:0] op;
            op = legal[$urandom_range(8)];
`ifdef M_EXT_EN
            bus0.funct7_0 = 1'b0;
`else
            bus0.funct7_0 = 1'($urandom_range(1));
`endif
            build(op, $urandom_range(3), $urandom_range(3));
            run_plan(op, $sformatf("rand %0d op %b", n, op), 1000);
        end
        bus0.funct7_0 = 1'b0;

        // Reset in the middle of a stalled load.
        do_reset();
        build(7'b0000011, 0, 5);
        run_plan(7'b0000011, "mid-read", 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid-read reset outputs", {8'd0, bus0.illegal, bus0.fault, bus0.state_o, got0},
              {14'd0, StReset, 18'd0});
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid-read reset held", {14'd0, bus0.state_o, got0}, {14'd0, StReset, 18'd0});
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus0.mem_ready = 1'b0;
        @(negedge clk);
        check("fetch after reset", {14'd0, got0},
              {14'd0, exp_ctrl(PhFetch, 1'b0, 7'b0000011)});

        // Illegal opcode traps and stays quiet whatever mem_ready does.
        do_reset();
        build(7'b0000000, 0, 0);
        run_plan(7'b0000000, "illegal", 1000);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            bus0.mem_ready = i[0];
            @(negedge clk);
            check($sformatf("trap quiet %0d", i),
                  {25'd0, bus0.pc_write, bus0.ir_write, bus0.reg_write, bus0.mem_read,
                   bus0.mem_write, bus0.illegal, bus0.fault}, 32'b0000010);
        end
        check("trap state", {28'd0, bus0.state_o}, {28'd0, StTrap});
        do_reset();
        @(negedge clk);
        check("illegal cleared", {31'd0, bus0.illegal}, 32'd0);

        // Bus timeout with TIMEOUT_CYCLES=4, and the ready-wins boundary.
        timeout_seq(0, "timeout");
        @(negedge clk);
        check("fault sticky", {30'd0, bus1.fault, bus1.pc_write}, 32'b10);
        timeout_seq(4, "ready wins");

`ifdef M_EXT_EN
        do_reset();
        bus0.funct7_0 = 1'b1;
        build(7'b0110011, 0, 0);
        plan.pop_back();  // MULDIV replaces WB_ALU
        run_plan(7'b0110011, "muldiv pre", 1000);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            bus0.muldiv_done = (c == 5);
            @(negedge clk);
            check($sformatf("muldiv c%0d", c),
                  {28'd0, bus0.muldiv_start, bus0.reg_write, bus0.mem_to_reg},
                  {28'd0, c == 1, c == 5, 2'b11});
        end
        @(posedge clk);
        #1;
        bus0.muldiv_done = 1'b0;
        bus0.mem_ready   = 1'b0;
        @(negedge clk);
        check("muldiv back to fetch", {14'd0, got0},
              {14'd0, exp_ctrl(PhFetch, 1'b0, 7'b0110011)});
        bus0.funct7_0 = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle successor to the single-cycle RV32I control unit: a Moore-style FSM that sequences fetch, decode, execute, memory and write-back over several cycles, sharing one memory port and one ALU. Covers the full RV32I base opcode map (R, I-ALU, load, store, branch, JAL, JALR, LUI, AUIPC), waits on a memory ready handshake, traps illegal opcodes and optional bus timeouts, and optionally sequences an external M-extension unit. Sits between the instruction register and the multi-cycle datapath muxes/enables.

## Interface
- TIMEOUT_CYCLES, 255, max consecutive wait cycles on memory before fault; 0 disables timeout
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instruction[6:0] from instruction register
- funct7_0  in  1  instruction[25] (M-extension select)
- mem_ready  in  1  memory completes current access this cycle
- muldiv_done  in  1  M unit result valid (only with M_EXT_EN)
- pc_write, ir_write, reg_write, mem_read, mem_write, branch  out  1 each
- iord  out  1  memory address: 0 PC, 1 ALUOut
- alu_src_a  out  2  00 PC, 01 rs1, 10 old_pc, 11 zero
- alu_src_b  out  2  00 rs2, 01 const 4, 10 imm
- aluop  out  2  00 add, 01 compare, 10 funct-decoded
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 ALU result & ~1
- mem_to_reg  out  2  00 ALUOut, 01 mem data, 10 PC (link), 11 M result
- muldiv_start  out  1  one-cycle start pulse
- illegal, fault  out  1  sticky trap causes
- state_o  out  4  current state, debug

## Operation
- States: RESET, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WRITE, WB_MEM, EXEC_R, EXEC_I, EXEC_U, WB_ALU, BRANCH, JAL, JALR, MULDIV, TRAP.
- RESET: all outputs 0; unconditionally to FETCH.
- FETCH: mem_read=1, iord=0, alu_src_a=00, alu_src_b=01, aluop=00. On mem_ready: ir_write=1, pc_write=1, pc_src=00, go DECODE; else stay.
- DECODE: alu_src_a=10, alu_src_b=10, aluop=00 (branch/JAL target into ALUOut). Dispatch: 0000011/0100011 MEM_ADDR; 0110011 EXEC_R; 0010011 EXEC_I; 0110111/0010111 EXEC_U; 1100011 BRANCH; 1101111 JAL; 1100111 JALR; else TRAP with illegal set.
- MEM_ADDR: a=01, b=10, aluop=00; load to MEM_READ, store to MEM_WRITE.
- MEM_READ/MEM_WRITE: strobe, iord=1, held until mem_ready; then WB_MEM / FETCH.
- WB_MEM: reg_write=1, mem_to_reg=01. EXEC_R: a=01, b=00, aluop=10. EXEC_I: a=01, b=10, aluop=10. EXEC_U: b=10, aluop=00, a=11 (LUI) or 10 (AUIPC). All three go WB_ALU: reg_write=1, mem_to_reg=00.
- BRANCH: a=01, b=00, aluop=01, branch=1, pc_src=01; datapath gates pc update by funct3 and comparison.
- JAL: pc_write=1, pc_src=01, reg_write=1, mem_to_reg=10. JALR: a=01, b=10, aluop=00, pc_write=1, pc_src=10, reg_write=1, mem_to_reg=10.
- All terminal states return to FETCH.
- TRAP: all strobes and write enables 0; exit only via rst_n; illegal/fault held.
- Timeout counter: counts FETCH/MEM_READ/MEM_WRITE cycles with mem_ready=0. Clears on state change. When count reaches TIMEOUT_CYCLES, next state is TRAP with fault=1. mem_ready in that same cycle wins, with no fault.
- Outputs decode from state only, except FETCH's ir_write/pc_write, which are qualified by mem_ready.

## Timing
- Zero-wait memory latencies, counted from FETCH entry to next FETCH:
  - BRANCH/JAL/JALR: 3 cycles.
  - R, I, U, store: 4 cycles.
  - Load: 5 cycles.
- Each memory wait cycle adds 1.
- rst_n assertion at any time (including mid-access): outputs 0 immediately, state RESET, counter 0, illegal/fault cleared. First FETCH is the cycle after release.
- mem_ready ignored outside FETCH/MEM_READ/MEM_WRITE.

## Configuration
- M_EXT_EN defined:
  - EXEC_R with funct7_0=1 goes to MULDIV instead of WB_ALU.
  - MULDIV pulses muldiv_start on entry cycle only, then waits for muldiv_done.
  - On muldiv_done: reg_write=1, mem_to_reg=11, go FETCH.
  - Wait counts toward timeout.
- M_EXT_EN undefined:
  - MULDIV state and muldiv_done port absent; muldiv_start tied 0.
  - funct7_0 ignored; all 0110011 execute via WB_ALU.

## Structure
- Shared package cu_pkg: state encoding, opcode constants, alu_src/pc_src/mem_to_reg/aluop encodings (shared with datapath muxes).
- One sub-module: cu_timeout_counter, width $clog2(TIMEOUT_CYCLES+1), inputs clear/count, output expired.

## Test plan
- Reset mid-MEM_READ (rst_n low 2 cycles) -> all outputs 0, state_o=RESET; FETCH with mem_read=1 one cycle after release.
- R-type 0110011, mem_ready=1 -> aluop=10 in cycle 3; reg_write=1, mem_to_reg=00 in cycle 4; FETCH in cycle 5.
- Load 0000011, mem_ready low 3 cycles in MEM_READ -> mem_read=1 and iord=1 for 4 cycles; WB_MEM reg_write=1, mem_to_reg=01; 8 cycles total.
- Opcode 0000000 -> TRAP, illegal=1; no pc_write/reg_write/mem_* for 20 cycles with mem_ready toggling.
- TIMEOUT_CYCLES=4, mem_ready stuck 0 in FETCH -> TRAP and fault=1 from cycle 5. Repeat with mem_ready=1 on cycle 4 -> DECODE, fault=0.
- M_EXT_EN, opcode 0110011, funct7_0=1, muldiv_done after 5 cycles -> single-cycle muldiv_start; reg_write=1, mem_to_reg=11 in done cycle; JAL run shows pc_write=1, mem_to_reg=10 in cycle 3.
